// File: rtl/frame_gen_param.sv
// frame_gen_param: parametrised 8b/10b test-frame generator for the GTP TX user interface.
// Link-up comma alignment, then framed table / counter / PRBS7 / comma payload.
module frame_gen_param #(
    parameter int         BYTES       = 2,
    parameter int         DEPTH       = 8,
    parameter int         FRAME_LEN   = 16,
    parameter int         ALIGN_WORDS = 4,
    parameter logic [7:0] COMMA       = 8'hBC
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     ready,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_addr,
    input  logic [8*BYTES-1:0]       tbl_data,
    input  logic [BYTES-1:0]         tbl_k,
    input  logic [$clog2(DEPTH):0]   tbl_len,
    output logic [8*BYTES-1:0]       tx_data,
    output logic [BYTES-1:0]         tx_is_k,
    output logic                     frame_start,
    output logic [31:0]              frame_cnt
);
    localparam int DW = 8 * BYTES;
    localparam int AB = $clog2(DEPTH);
    localparam int LB = AB + 1;
    localparam int WB = $clog2(FRAME_LEN);
    localparam int CB = (ALIGN_WORDS > 0) ? $clog2(ALIGN_WORDS + 1) : 1;
    localparam int ADONE = (ALIGN_WORDS > 0) ? ALIGN_WORDS - 1 : 0;

    localparam logic [DW-1:0] COMMA_W = {BYTES{COMMA}};
    localparam logic [WB-1:0] W_LAST  = WB'(FRAME_LEN - 1);
    localparam logic [CB-1:0] A_LAST  = CB'(ADONE);
    localparam logic [CB-1:0] A_SAT   = CB'(ALIGN_WORDS);
    localparam logic [LB-1:0] LEN_MAX = LB'(DEPTH);

    typedef enum logic [1:0] {
        S_OFF,
        S_ALIGN,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [WB-1:0]   w_q, w_d;
    logic [CB-1:0]   acnt_q, acnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [AB-1:0]   p_q, p_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [6:0]      lfsr_q, lfsr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [BYTES-1:0] k_q, k_d;
    logic            fs_q, fs_d;
    logic [31:0]     fcnt_q, fcnt_d;

    logic [DW-1:0]    mem_data_q [DEPTH];
    logic [BYTES-1:0] mem_k_q    [DEPTH];

    always_ff @(posedge aclk) begin
        if (tbl_we) begin
            mem_data_q[tbl_addr] <= tbl_data;
            mem_k_q[tbl_addr]    <= tbl_k;
        end
    end

    // Pointer is clamped into the active window in case tbl_len shrinks mid-frame.
    logic [LB-1:0] len;
    logic [AB-1:0] p_cur, p_inc;

    always_comb begin
        len   = (tbl_len == '0 || tbl_len > LEN_MAX) ? LEN_MAX : tbl_len;
        p_cur = ({1'b0, p_q} < len) ? p_q : '0;
        p_inc = ({1'b0, p_cur} + LB'(1) == len) ? '0 : p_cur + AB'(1);
    end

    logic [6:0]    lfsr_adv;
    logic [DW-1:0] prbs_word;

    always_comb begin
        lfsr_adv  = lfsr_q;
        prbs_word = '0;
        for (int i = 0; i < DW; i++) begin
            prbs_word[i] = lfsr_adv[6] ^ lfsr_adv[5];
            lfsr_adv     = {lfsr_adv[5:0], prbs_word[i]};
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        acnt_d  = acnt_q;
        mode_d  = mode_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        data_d  = '0;
        k_d     = '0;
        fs_d    = 1'b0;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_OFF: begin
                if (ready) begin
                    state_d = S_ALIGN;
                    acnt_d  = '0;
                    lfsr_d  = 7'h7F;
                end
            end
            S_ALIGN: begin
                if (!ready) begin
                    state_d = S_OFF;
                end else begin
                    data_d = COMMA_W;
                    k_d    = '1;
                    if (acnt_q >= A_LAST) begin
                        acnt_d = A_SAT;
                        if (enable) begin
                            state_d = S_RUN;
                            w_d     = '0;
                        end
                    end else begin
                        acnt_d = acnt_q + CB'(1);
                    end
                end
            end
            S_RUN: begin
                if (!ready) begin
                    state_d = S_OFF;
                end else begin
                    if (w_q == '0) begin
                        data_d = COMMA_W;
                        k_d    = '1;
                        fs_d   = 1'b1;
                        fcnt_d = fcnt_q + 32'd1;
                        mode_d = mode;
                        p_d    = '0;
                        cnt_d  = '0;
                    end else begin
                        unique case (mode_q)
                            2'd0: begin
                                data_d = mem_data_q[p_cur];
                                k_d    = mem_k_q[p_cur];
                            end
                            2'd1: data_d = cnt_q;
                            2'd2: begin
                                data_d = prbs_word;
                                lfsr_d = lfsr_adv;
                            end
                            default: begin
                                data_d = COMMA_W;
                                k_d    = '1;
                            end
                        endcase
                        p_d   = p_inc;
                        cnt_d = cnt_q + DW'(1);
                    end
                    if (w_q == W_LAST) begin
                        w_d = '0;
                        if (!enable) begin
                            state_d = S_ALIGN;
                            acnt_d  = A_SAT;
                        end
                    end else begin
                        w_d = w_q + WB'(1);
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_OFF;
            w_q     <= '0;
            acnt_q  <= '0;
            mode_q  <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            lfsr_q  <= 7'h7F;
            data_q  <= '0;
            k_q     <= '0;
            fs_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            acnt_q  <= acnt_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            k_q     <= k_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign tx_data     = data_q;
    assign tx_is_k     = k_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_frame_gen_param.sv
// tb_frame_gen_param: vector table, hand-written corner sequences and
// randomized traffic against a word-level reference model.
module tb_frame_gen_param;
    localparam int BY    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AB    = 3;
    localparam int FL    = 16;
    localparam int AW    = 4;
    localparam logic [15:0] CW = 16'hBCBC;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          ready = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          tbl_we = 1'b0;
    logic [AB-1:0] tbl_addr = '0;
    logic [DW-1:0] tbl_data = '0;
    logic [BY-1:0] tbl_k = '0;
    logic [AB:0]   tbl_len = '0;
    logic [DW-1:0] tx_data;
    logic [BY-1:0] tx_is_k;
    logic          frame_start;
    logic [31:0]   frame_cnt;

    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    frame_gen_param #(
        .BYTES(BY), .DEPTH(DEPTH), .FRAME_LEN(FL),
        .ALIGN_WORDS(AW), .COMMA(8'hBC)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .ready(ready), .enable(enable),
        .mode(mode), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_k(tbl_k), .tbl_len(tbl_len),
        .tx_data(tx_data), .tx_is_k(tx_is_k),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // Reference model: link flag, commas since link-up, next word index (-1 = idle)
    bit            m_up;
    int            m_aligned;
    int            m_w;
    logic [31:0]   m_fcnt;
    logic [1:0]    m_mode;
    logic [6:0]    m_lfsr;
    logic [DW-1:0] m_tbl [DEPTH];
    logic [BY-1:0] m_tk  [DEPTH];

    bit last_fs;
    bit last_prbs;
    bit collect = 1'b0;
    bit pq[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_up = 1'b0;
        m_aligned = 0;
        m_w = -1;
        m_fcnt = '0;
        m_mode = 2'd0;
        m_lfsr = 7'h7F;
    endtask

    function automatic bit prbs_bit();
        bit nb;
        nb = m_lfsr[6] ^ m_lfsr[5];
        m_lfsr = {m_lfsr[5:0], nb};
        return nb;
    endfunction

    task automatic model_step(output logic [DW-1:0] ed, output logic [BY-1:0] ek,
                              output bit efs, output bit eprbs);
        int mlen;
        int idx;
        ed = '0;
        ek = '0;
        efs = 1'b0;
        eprbs = 1'b0;
        mlen = (tbl_len == 0 || int'(tbl_len) > DEPTH) ? DEPTH : int'(tbl_len);
        if (!ready) begin
            m_up = 1'b0;
        end else if (!m_up) begin
            m_up = 1'b1;
            m_aligned = 0;
            m_w = -1;
            m_lfsr = 7'h7F;
        end else if (m_w < 0) begin
            ed = CW;
            ek = '1;
            m_aligned++;
            if (m_aligned >= AW && enable) m_w = 0;
        end else begin
            if (m_w == 0) begin
                ed = CW;
                ek = '1;
                efs = 1'b1;
                m_fcnt = m_fcnt + 32'd1;
                m_mode = mode;
            end else begin
                case (m_mode)
                    2'd0: begin
                        idx = (m_w - 1) % mlen;
                        ed = m_tbl[idx];
                        ek = m_tk[idx];
                    end
                    2'd1: ed = DW'(m_w - 1);
                    2'd2: begin
                        for (int b = 0; b < DW; b++) ed[b] = prbs_bit();
                        eprbs = 1'b1;
                    end
                    default: begin
                        ed = CW;
                        ek = '1;
                    end
                endcase
            end
            if (m_w == FL - 1) m_w = enable ? 0 : -1;
            else m_w++;
        end
        if (tbl_we) begin
            m_tbl[tbl_addr] = tbl_data;
            m_tk[tbl_addr] = tbl_k;
        end
    endtask

    task automatic cyc();
        logic [DW-1:0] ed;
        logic [BY-1:0] ek;
        bit efs;
        bit ep;
        model_step(ed, ek, efs, ep);
        @(posedge aclk);
        @(negedge aclk);
        last_fs = efs;
        last_prbs = ep;
        chk("cycle", 64'({tx_data, tx_is_k, frame_start, frame_cnt}),
            64'({ed, ek, efs, m_fcnt}));
        if (collect && ep)
            for (int b = 0; b < DW; b++) pq.push_back(tx_data[b]);
    endtask

    task automatic wait_fs(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            seen = last_fs;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no frame start within 64 cycles", nm);
        end
    endtask

    typedef struct {
        bit          r;
        bit          e;
        bit [1:0]    md;
        logic [15:0] d;
        logic [1:0]  k;
        bit          fs;
        logic [31:0] fc;
    } vec_t;

    vec_t vt[25];
    logic [15:0] pat[3];
    logic [31:0] fc_hold;
    int perr;
    int lens[3];

    initial begin
        pat[0] = 16'h5854;
        pat[1] = 16'h4034;
        pat[2] = 16'h23A7;
        lens[0] = 0;
        lens[1] = 5;
        lens[2] = 13;
        for (int i = 0; i < 25; i++) begin
            vt[i].r = 1'b1;
            vt[i].e = (i >= 7);
            vt[i].md = 2'd1;
            if (i == 0) begin
                vt[i].d = '0; vt[i].k = '0; vt[i].fs = 0; vt[i].fc = 0;
            end else if (i <= 7) begin
                vt[i].d = CW; vt[i].k = 2'b11; vt[i].fs = 0; vt[i].fc = 0;
            end else if (i == 8) begin
                vt[i].d = CW; vt[i].k = 2'b11; vt[i].fs = 1; vt[i].fc = 1;
            end else if (i < 24) begin
                vt[i].d = 16'(i - 9); vt[i].k = '0; vt[i].fs = 0; vt[i].fc = 1;
            end else begin
                vt[i].d = CW; vt[i].k = 2'b11; vt[i].fs = 1; vt[i].fc = 2;
            end
        end

        model_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_out", 64'({tx_data, tx_is_k, frame_start, frame_cnt}), 64'd0);
        aresetn = 1'b1;

        tbl_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_addr = AB'(i);
            tbl_data = DW'($urandom);
            tbl_k = BY'($urandom);
            cyc();
        end
        tbl_we = 1'b0;

        for (int i = 0; i < 25; i++) begin
            ready = vt[i].r;
            enable = vt[i].e;
            mode = vt[i].md;
            cyc();
            chk($sformatf("vec%0d", i),
                64'({tx_data, tx_is_k, frame_start, frame_cnt}),
                64'({vt[i].d, vt[i].k, vt[i].fs, vt[i].fc}));
        end

        tbl_we = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tbl_addr = AB'(j);
            tbl_data = pat[j];
            tbl_k = 2'b00;
            cyc();
        end
        tbl_we = 1'b0;
        tbl_len = 4'd3;
        mode = 2'd0;
        wait_fs("tbl_start");
        for (int j = 0; j < FL - 1; j++) begin
            cyc();
            chk($sformatf("tbl_w%0d", j + 1), 64'({tx_is_k, tx_data}),
                64'({2'b00, pat[j % 3]}));
        end
        cyc();
        chk("tbl_next_fs", 64'(frame_start), 64'd1);
        cyc();
        chk("tbl_restart", 64'(tx_data), 64'(16'h5854));

        mode = 2'd1;
        wait_fs("drop_start");
        repeat (4) cyc();
        enable = 1'b0;
        for (int j = 0; j < 11; j++) begin
            cyc();
            chk($sformatf("drop_w%0d", j + 5), 64'({tx_is_k, tx_data}),
                64'({2'b00, 16'(j + 4)}));
        end
        fc_hold = m_fcnt;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("fill", 64'({frame_start, tx_is_k, tx_data, frame_cnt}),
                64'({1'b0, 2'b11, CW, fc_hold}));
        end
        enable = 1'b1;
        cyc();
        chk("reen_fill", 64'(frame_start), 64'd0);
        cyc();
        chk("reen_fs", 64'({frame_start, frame_cnt}), 64'({1'b1, fc_hold + 32'd1}));

        repeat (6) cyc();
        fc_hold = m_fcnt;
        ready = 1'b0;
        cyc();
        chk("rdy_off1", 64'({tx_data, tx_is_k, frame_start}), 64'd0);
        chk("rdy_cnt", 64'(frame_cnt), 64'(fc_hold));
        cyc();
        chk("rdy_off2", 64'({tx_data, tx_is_k, frame_start}), 64'd0);
        ready = 1'b1;
        cyc();
        chk("rdy_relink", 64'({tx_data, tx_is_k}), 64'd0);
        for (int j = 0; j < AW; j++) begin
            cyc();
            chk($sformatf("realign%0d", j),
                64'({frame_start, tx_is_k, tx_data}), 64'({1'b0, 2'b11, CW}));
        end
        cyc();
        chk("rdy_fs", 64'({frame_start, frame_cnt}), 64'({1'b1, fc_hold + 32'd1}));

        repeat (3) cyc();
        #2 aresetn = 1'b0;
        #1 chk("areset", 64'({tx_data, tx_is_k, frame_start, frame_cnt}), 64'd0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;

        mode = 2'd2;
        enable = 1'b1;
        collect = 1'b1;
        wait_fs("prbs_start");
        cyc();
        chk("prbs_first", 64'(tx_data), 64'(16'h3040));
        repeat (44) cyc();
        collect = 1'b0;
        perr = 0;
        for (int i = 0; i + 127 < pq.size(); i++)
            if (pq[i] != pq[i + 127]) perr++;
        chk("prbs_period", 64'(perr), 64'd0);

        for (int b = 0; b < 3; b++) begin
            ready = 1'b0;
            cyc();
            cyc();
            ready = 1'b1;
            tbl_len = 4'(lens[b]);
            for (int n = 0; n < 1000; n++) begin
                ready = ($urandom_range(99) != 0);
                if ($urandom_range(19) == 0) enable = ~enable;
                mode = 2'($urandom);
                tbl_we = ($urandom_range(3) == 0);
                tbl_addr = AB'($urandom);
                tbl_data = DW'($urandom);
                tbl_k = BY'($urandom);
                cyc();
            end
            tbl_we = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_gen_param.md
Name: frame_gen_param

Overview:
- Parametrised successor to the fixed 8b/10b test-frame generator on the SFP transmit path.
- Feeds a GTP TX user interface: 8*BYTES data bits plus BYTES is-K flags per tx clock.
- Frames start with a K28.5 comma word, followed by FRAME_LEN-1 payload words.
- Payload is selectable per frame: a runtime-loadable pattern table, an incrementing counter, or PRBS7.
- Adds link-up alignment fill, graceful stop at frame boundary and a frame counter.

Parameters:
- BYTES, 2, byte lanes per word; lane 0 = tx_data[7:0], transmitted first.
- DEPTH, 8, pattern table entries; power of two, at least 2.
- FRAME_LEN, 16, words per frame including the comma word; at least 2.
- ALIGN_WORDS, 4, comma words emitted after ready rises, before any frame.
- COMMA, 8'hBC, K-character byte (K28.5).

Ports:
- aclk  in  1  TX user clock.
- aresetn  in  1  Asynchronous active-low reset.
- ready  in  1  Transceiver TX reset done / link usable.
- enable  in  1  Request frame generation.
- mode  in  2  Payload source: 0 table, 1 counter, 2 PRBS7, 3 comma fill.
- tbl_we  in  1  Pattern table write strobe.
- tbl_addr  in  $clog2(DEPTH)  Table write address.
- tbl_data  in  8*BYTES  Table entry data.
- tbl_k  in  BYTES  Table entry is-K flags.
- tbl_len  in  $clog2(DEPTH)+1  Active entries; 0 or >DEPTH is clamped to DEPTH.
- tx_data  out  8*BYTES  Word to transceiver.
- tx_is_k  out  BYTES  Per-lane K flag.
- frame_start  out  1  High in the cycle tx_data holds a frame's comma word.
- frame_cnt  out  32  Frames started since reset; wraps at 2^32.

Behaviour:
- Reset (asynchronous): all outputs 0, state OFF, counters 0, LFSR = 7'h7F. Table contents are not reset.
- All outputs are registered. The word chosen in cycle N appears on the outputs in cycle N+1.
- Comma word: every lane equals COMMA and tx_is_k is all ones.

States:
- OFF: outputs 0. If ready=1, go to ALIGN with the align counter cleared.
- ALIGN: emit comma words. After ALIGN_WORDS words, if enable=1 go to RUN at w=0; otherwise keep emitting comma words (idle fill).
- RUN: word index w counts 0..FRAME_LEN-1 and wraps to 0.
  - At w=0: emit a comma word, assert frame_start, increment frame_cnt, latch mode.
  - At w>0: emit a payload word.
  - If enable=0 when w=FRAME_LEN-1, the frame completes and the state goes to ALIGN with the align counter already satisfied (idle fill, no re-alignment).
- ready=0 in any state: go to OFF next cycle and drive outputs to 0 from the following cycle. The current frame is aborted and frame_cnt is held.

Payload modes:
- Mode 0 (table): pointer p resets to 0 at each frame start and advances per payload word, wrapping from len-1 to 0. Output = entry p data, is_k = entry p flags.
- Mode 1 (counter): a 8*BYTES-bit counter, cleared at frame start, gives values 0,1,2,... on payload words. tx_is_k = 0.
- Mode 2 (PRBS7): polynomial x^7+x^6+1, new bit = s[6]^s[5], shifted in at s[0]. The LFSR advances 8*BYTES bits per payload word; bit 0 of the word is the first bit generated. It is not reset at frame boundaries and is reseeded to 7'h7F only on entering ALIGN from OFF. tx_is_k = 0.
- Mode 3: payload words are comma words.
- Changes to mode mid-frame take effect at the next frame start. tbl_len is sampled at each payload word.

Table:
- Single write port, one write per cycle.
- A write and a read to the same address in one cycle return the old data; the new data is visible the next cycle.
- Writes are allowed in every state.

Test Plan:
- Reset then ready=1, enable=0 -> outputs 0 for 1 cycle, then continuous 16'hBCBC with is_k=2'b11; frame_start stays 0 and frame_cnt stays 0.
- ready=1, enable=1, mode=1 -> after 4 align words, frame 0 = BCBC/K with frame_start=1, then payload 0x0000..0x000E with is_k=0, then the next comma; frame_cnt reaches 1, then 2.
- Mode 0, table loaded with {5854,4034,23A7} plus K flags 00, tbl_len=3 -> payload sequence 5854,4034,23A7,5854,... restarting at 5854 after each comma.
- Mode 2 -> payload matches the software PRBS7 model bit-exactly; the bit stream repeats with period 127; comma words are not counted toward the LFSR.
- enable dropped at w=5 -> words 6..15 of that frame are still payload, then comma fill with no frame_start; raising enable again starts a frame on the next word boundary.
- ready dropped at w=7 -> outputs 0 within 2 cycles and frame_cnt held. Re-raising ready -> a full 4-word align sequence, then frame_cnt increments by 1 at the next frame. Asserting aresetn low mid-frame forces outputs 0 immediately.
